m_popcount_stream: RTL

//  Pipelined, streaming population counter with valid/ready handshake.
//  - Counts ones, or zeros when the mode bit is set, in each DATA_WIDTH-bit beat.
//  - Also keeps a saturating running total across a burst delimited by i_last.
//  - Sits between a pixel/data producer and the display-control logic; replaces ad-hoc combinational counting on wide buses.

---
 rtl/m_popcount_stream_pkg.sv | 33 +++
 rtl/m_popcount_stream_chunk.sv | 23 ++
 rtl/m_popcount_stream.sv | 101 ++++++++++
 3 files changed

// File: rtl/m_popcount_stream_pkg.sv
// Shared widths and helpers for the streaming population counter.
package pkg_popcount;

  localparam int unsigned SAT_W = 63;

  typedef struct packed {
    logic             ovf;
    logic [SAT_W:0]   val;
  } sat_res_t;

  function automatic int unsigned f_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned f_num_chunks(input int unsigned dw, input int unsigned cw);
    return (dw + cw - 1) / cw;
  endfunction

  // Adds two values and clamps the result to 2**width-1.
  function automatic sat_res_t f_sat_add(input logic [SAT_W-1:0] a,
                                         input logic [SAT_W-1:0] b,
                                         input int unsigned      width);
    logic [SAT_W:0] raw;
    logic [SAT_W:0] lim;
    sat_res_t       r;
    raw = {1'b0, a} + {1'b0, b};
    lim = ((SAT_W + 1)'(1) << width) - (SAT_W + 1)'(1);
    r.ovf = (raw > lim);
    r.val = r.ovf ? lim : raw;
    return r;
  endfunction

endpackage

// File: rtl/m_popcount_stream_chunk.sv
// Combinational ones/zeros counter for one chunk of a beat.
module m_popcount_chunk
  import pkg_popcount::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = f_cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] i_bits,
  input  logic             i_mode,
  output logic [OUT_W-1:0] o_count
);

  logic [WIDTH-1:0] sel;

  always_comb begin
    sel     = i_mode ? ~i_bits : i_bits;
    o_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_count = o_count + OUT_W'(sel[i]);
    end
  end

endmodule

// File: rtl/m_popcount_stream.sv
// Two-stage streaming popcount with valid/ready and a saturating per-burst total.
module m_popcount_stream
  import pkg_popcount::*;
#(
  parameter  int unsigned DATA_WIDTH  = 42,
  parameter  int unsigned CHUNK_WIDTH = 8,
  parameter  int unsigned ACC_WIDTH   = 16,
  localparam int unsigned CNT_W       = f_cnt_w(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_mode,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [CNT_W-1:0]      o_count,
  output logic [ACC_WIDTH-1:0]  o_acc,
  output logic                  o_acc_sat,
  output logic                  o_last
);

  localparam int unsigned CHUNK_CNT_W = f_cnt_w(CHUNK_WIDTH);
  localparam int unsigned NUM_CHUNKS  = f_num_chunks(DATA_WIDTH, CHUNK_WIDTH);

  logic [CHUNK_CNT_W-1:0] chunk_cnt_d [NUM_CHUNKS];
  logic [CHUNK_CNT_W-1:0] chunk_cnt_q [NUM_CHUNKS];
  logic                   valid_s1_q, last_s1_q;
  logic                   valid_s2_q, last_s2_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_base;
  logic                   sat_q, sat_d, ovf;
  logic                   burst_start_q;
  logic                   en;
  sat_res_t               acc_res;

  // The top chunk is narrowed so padding bits never exist to be inverted or counted.
  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_chunk
    localparam int unsigned LO = g * CHUNK_WIDTH;
    localparam int unsigned W  = (DATA_WIDTH - LO < CHUNK_WIDTH) ? DATA_WIDTH - LO : CHUNK_WIDTH;
    m_popcount_chunk #(
      .WIDTH (W),
      .OUT_W (CHUNK_CNT_W)
    ) u_chunk (
      .i_bits  (i_data[LO +: W]),
      .i_mode  (i_mode),
      .o_count (chunk_cnt_d[g])
    );
  end

  assign en = !valid_s2_q || i_ready;

  always_comb begin
    count_d = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      count_d = count_d + CNT_W'(chunk_cnt_q[i]);
    end
    acc_base = burst_start_q ? '0 : acc_q;
    acc_res  = f_sat_add(SAT_W'(acc_base), SAT_W'(count_d), ACC_WIDTH);
    acc_d    = acc_res.val[ACC_WIDTH-1:0];
    ovf      = acc_res.ovf | (|acc_res.val[SAT_W:ACC_WIDTH]);
    sat_d    = (burst_start_q ? 1'b0 : sat_q) | ovf;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      chunk_cnt_q   <= '{default: '0};
      valid_s1_q    <= 1'b0;
      last_s1_q     <= 1'b0;
      valid_s2_q    <= 1'b0;
      last_s2_q     <= 1'b0;
      count_q       <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      burst_start_q <= 1'b1;
    end else if (en) begin
      chunk_cnt_q <= chunk_cnt_d;
      valid_s1_q  <= i_valid;
      last_s1_q   <= i_valid && i_last;
      valid_s2_q  <= valid_s1_q;
      last_s2_q   <= last_s1_q;
      count_q     <= count_d;
      // Burst state only moves on real beats so bubbles never split a burst.
      if (valid_s1_q) begin
        acc_q         <= acc_d;
        sat_q         <= sat_d;
        burst_start_q <= last_s1_q;
      end
    end
  end

  assign o_ready   = en;
  assign o_valid   = valid_s2_q;
  assign o_count   = count_q;
  assign o_acc     = acc_q;
  assign o_acc_sat = sat_q;
  assign o_last    = last_s2_q;

endmodule
